move_frame_arbiter: RTL and testbench

Sequencer between the four player buttons and the shared LED-line refresh path of the LEDs racer game. It queues debounced press pulses per player and grants them one at a time, round-robin, to the position updater. After each accepted move it launches exactly one LED-line frame and waits for that frame to complete before granting the next move. It sits inside the game core, between the per-button debouncers and the position/frame logic.

---
 rtl/leds_racer_pkg.sv | 19 +
 rtl/move_frame_arbiter_if.sv | 27 ++
 rtl/rr_pick4.sv | 20 ++
 rtl/move_frame_arbiter.sv | 122 ++++++++++++
 tb/tb_move_frame_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/leds_racer_pkg.sv
// Shared definitions for the LEDs racer game core: player indices,
// the move/frame arbiter state encoding and the default pending-counter width.
package leds_racer_pkg;

  localparam logic [1:0] BLUE   = 2'd0;
  localparam logic [1:0] RED    = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;
  localparam logic [1:0] YELLOW = 2'd3;

  localparam int PEND_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    FRAME     = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/move_frame_arbiter_if.sv
// Button/move/frame signal bundle of the arbiter. The master modport is the
// arbiter itself; the slave modport is the surrounding game logic.
interface move_frame_arbiter_if;

  logic [3:0] press_in;
  logic       enable;
  logic       move_valid;
  logic [1:0] move_player;
  logic       move_ready;
  logic       frame_start;
  logic       frame_busy;
  logic       frame_done;
  logic [3:0] pending;
  logic [3:0] dropped;
  logic       timeout_flag;

  modport master (
    input  press_in, enable, move_ready, frame_busy, frame_done,
    output move_valid, move_player, frame_start, pending, dropped, timeout_flag
  );

  modport slave (
    output press_in, enable, move_ready, frame_busy, frame_done,
    input  move_valid, move_player, frame_start, pending, dropped, timeout_flag
  );

endinterface

// File: rtl/rr_pick4.sv
// Combinational rotate-priority picker over four requesters: the first set
// request at or after start (wrapping) wins.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] start,
  output logic [1:0] grant,
  output logic       any
);

  // Scan from the farthest offset down so the nearest request overwrites last.
  always_comb begin
    grant = start;
    for (int k = 3; k >= 0; k--) begin
      if (req[start + 2'(k)]) grant = start + 2'(k);
    end
  end

  assign any = |req;

endmodule

// File: rtl/move_frame_arbiter.sv
// Queues per-player press pulses and grants them round-robin, one LED-line
// frame per accepted move. Optional frame watchdog: define ARB_TIMEOUT_EN.
module move_frame_arbiter
  import leds_racer_pkg::*;
#(
  parameter int PEND_W      = PEND_W_DEF,
  parameter int TIMEOUT_CYC = 4_000_000
) (
  input logic                  clk,
  input logic                  rst_n,
  move_frame_arbiter_if.master bus
);

  localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

  arb_state_t        state, state_nxt;
  logic [PEND_W-1:0] cnt [4];
  logic [3:0]        req;
  logic [3:0]        drop_q;
  logic [1:0]        rr_ptr, pick, player;
  logic              any_req, accept, launch, wd_expire, timeout_q;

  always_comb begin
    for (int i = 0; i < 4; i++) req[i] = (cnt[i] != '0);
  end

  rr_pick4 u_pick (
    .req   (req),
    .start (rr_ptr),
    .grant (pick),
    .any   (any_req)
  );

  assign accept = (state == GRANT) && bus.move_ready && bus.enable;

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    if (!bus.enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      if (any_req) state_nxt = GRANT;
        GRANT:     if (bus.move_ready) state_nxt = FRAME;
        FRAME: begin
          if (!bus.frame_busy) begin
            launch    = 1'b1;
            state_nxt = WAIT_DONE;
          end
        end
        WAIT_DONE: if (bus.frame_done || wd_expire) state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      player <= '0;
      rr_ptr <= '0;
    end else begin
      if (state == IDLE && bus.enable && any_req) player <= pick;
      if (accept) rr_ptr <= player + 2'd1;
    end
  end

  // A press and a grant on the same player cancel; a press at saturation is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      drop_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!bus.enable) begin
          cnt[i] <= '0;
        end else if (bus.press_in[i] && !(accept && player == 2'(i))) begin
          if (cnt[i] == CNT_MAX) drop_q[i] <= 1'b1;
          else                   cnt[i]    <= cnt[i] + PEND_W'(1);
        end else if (!bus.press_in[i] && accept && player == 2'(i)) begin
          cnt[i] <= cnt[i] - PEND_W'(1);
        end
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt;

  assign wd_expire = (state == WAIT_DONE) && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt <= (state == WAIT_DONE) ? wd_cnt + WD_W'(1) : '0;
      if (wd_expire && !bus.frame_done && bus.enable) timeout_q <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = (TIMEOUT_CYC != 0);
  assign wd_expire  = 1'b0;
  assign timeout_q  = 1'b0;
`endif

  assign bus.move_valid   = (state == GRANT);
  assign bus.move_player  = player;
  assign bus.frame_start  = launch;
  assign bus.pending      = req;
  assign bus.dropped      = drop_q;
  assign bus.timeout_flag = timeout_q;

endmodule

// File: tb/tb_move_frame_arbiter.sv
// Directed bench for move_frame_arbiter: per-cycle vector table plus short
// hand-written sequences for latency, frame_busy gating and the watchdog.
module tb_move_frame_arbiter;
  import leds_racer_pkg::*;

  typedef struct {
    logic       rst;
    logic [3:0] press;
    logic       en, rdy, busy, done;
    logic       vld;
    logic [1:0] ply;
    logic       start;
    logic [3:0] pend, drop;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t vq[$];

  move_frame_arbiter_if bus ();

  move_frame_arbiter #(.PEND_W(2), .TIMEOUT_CYC(50)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, k, act, exp);
    end
  endtask

  function automatic void v(input logic [3:0] p, input logic en, input logic rdy,
                            input logic busy, input logic done, input logic vld,
                            input logic [1:0] ply, input logic st,
                            input logic [3:0] pend, input logic [3:0] drop);
    vec_t t;
    t.rst = 1'b0; t.press = p; t.en = en; t.rdy = rdy; t.busy = busy; t.done = done;
    t.vld = vld; t.ply = ply; t.start = st; t.pend = pend; t.drop = drop;
    vq.push_back(t);
  endfunction

  function automatic void vr();
    vec_t t;
    t.rst = 1'b1; t.press = 4'h0; t.en = 1'b1; t.rdy = 1'b0; t.busy = 1'b0; t.done = 1'b0;
    t.vld = 1'b0; t.ply = 2'd0; t.start = 1'b0; t.pend = 4'h0; t.drop = 4'h0;
    vq.push_back(t);
  endfunction

  // Quiet cycle with the updater ready and the LED line idle.
  function automatic void q(input logic done, input logic vld, input logic [1:0] ply,
                            input logic st, input logic [3:0] pend, input logic [3:0] drop);
    v(4'h0, 1'b1, 1'b1, 1'b0, done, vld, ply, st, pend, drop);
  endfunction

  task automatic drive_idle();
    bus.press_in = 4'h0; bus.enable = 1'b1; bus.move_ready = 1'b0;
    bus.frame_busy = 1'b0; bus.frame_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    drive_idle();

    // Single red press
    vr();
    v(4'h2, 1, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    q(0, 0, 0, 0, 4'h2, 4'h0);
    q(0, 1, RED, 0, 4'h2, 4'h0);
    q(0, 0, 0, 1, 4'h0, 4'h0);
    q(0, 0, 0, 0, 4'h0, 4'h0);
    q(1, 0, 0, 0, 4'h0, 4'h0);
    q(0, 0, 0, 0, 4'h0, 4'h0);

    // All four at once, first frame_done delayed two cycles
    vr();
    v(4'hF, 1, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    q(0, 0, 0, 0, 4'hF, 4'h0);
    q(0, 1, BLUE, 0, 4'hF, 4'h0);
    q(0, 0, 0, 1, 4'hE, 4'h0);
    q(0, 0, 0, 0, 4'hE, 4'h0);
    q(0, 0, 0, 0, 4'hE, 4'h0);
    q(1, 0, 0, 0, 4'hE, 4'h0);
    q(0, 0, 0, 0, 4'hE, 4'h0);
    q(0, 1, RED, 0, 4'hE, 4'h0);
    q(0, 0, 0, 1, 4'hC, 4'h0);
    q(1, 0, 0, 0, 4'hC, 4'h0);
    q(0, 0, 0, 0, 4'hC, 4'h0);
    q(0, 1, GREEN, 0, 4'hC, 4'h0);
    q(0, 0, 0, 1, 4'h8, 4'h0);
    q(1, 0, 0, 0, 4'h8, 4'h0);
    q(0, 0, 0, 0, 4'h8, 4'h0);
    q(0, 1, YELLOW, 0, 4'h8, 4'h0);
    q(0, 0, 0, 1, 4'h0, 4'h0);
    q(1, 0, 0, 0, 4'h0, 4'h0);
    q(1, 0, 0, 0, 4'h0, 4'h0);
    q(0, 0, 0, 0, 4'h0, 4'h0);

    // Blue overflow while the frame is held busy for 10 cycles
    vr();
    v(4'h1, 1, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    q(0, 0, 0, 0, 4'h1, 4'h0);
    q(0, 1, BLUE, 0, 4'h1, 4'h0);
    v(4'h1, 1, 1, 1, 0, 0, 0, 0, 4'h0, 4'h0);
    v(4'h1, 1, 1, 1, 0, 0, 0, 0, 4'h1, 4'h0);
    v(4'h1, 1, 1, 1, 0, 0, 0, 0, 4'h1, 4'h0);
    v(4'h1, 1, 1, 1, 0, 0, 0, 0, 4'h1, 4'h0);
    v(4'h1, 1, 1, 1, 0, 0, 0, 0, 4'h1, 4'h1);
    for (int i = 0; i < 5; i++) v(4'h0, 1, 1, 1, 0, 0, 0, 0, 4'h1, 4'h1);
    q(0, 0, 0, 1, 4'h1, 4'h1);
    q(1, 0, 0, 0, 4'h1, 4'h1);
    for (int g = 0; g < 3; g++) begin
      q(0, 0, 0, 0, 4'h1, 4'h1);
      q(0, 1, BLUE, 0, 4'h1, 4'h1);
      q(0, 0, 0, 1, (g < 2) ? 4'h1 : 4'h0, 4'h1);
      q(1, 0, 0, 0, (g < 2) ? 4'h1 : 4'h0, 4'h1);
    end
    q(0, 0, 0, 0, 4'h0, 4'h1);
    q(0, 0, 0, 0, 4'h0, 4'h1);
    v(4'h1, 0, 1, 0, 0, 0, 0, 0, 4'h0, 4'h1);
    v(4'h0, 0, 1, 0, 0, 0, 0, 0, 4'h0, 4'h1);

    // Green press in the cycle its move is accepted
    vr();
    v(4'h4, 1, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    q(0, 0, 0, 0, 4'h4, 4'h0);
    v(4'h4, 1, 1, 0, 0, 1, GREEN, 0, 4'h4, 4'h0);
    q(0, 0, 0, 1, 4'h4, 4'h0);
    q(1, 0, 0, 0, 4'h4, 4'h0);
    q(0, 0, 0, 0, 4'h4, 4'h0);
    q(0, 1, GREEN, 0, 4'h4, 4'h0);
    q(0, 0, 0, 1, 4'h0, 4'h0);
    q(1, 0, 0, 0, 4'h0, 4'h0);
    q(0, 0, 0, 0, 4'h0, 4'h0);

    // enable dropped mid-GRANT, then reset mid-WAIT_DONE
    vr();
    v(4'h8, 1, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    q(0, 0, 0, 0, 4'h8, 4'h0);
    v(4'h0, 1, 0, 0, 0, 1, YELLOW, 0, 4'h8, 4'h0);
    v(4'h0, 0, 0, 0, 0, 1, YELLOW, 0, 4'h8, 4'h0);
    v(4'h0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    v(4'h2, 1, 1, 0, 0, 0, 0, 0, 4'h0, 4'h0);
    q(0, 0, 0, 0, 4'h2, 4'h0);
    q(0, 1, RED, 0, 4'h2, 4'h0);
    v(4'h1, 1, 1, 0, 0, 0, 0, 1, 4'h0, 4'h0);
    q(0, 0, 0, 0, 4'h1, 4'h0);
    vr();
    q(0, 0, 0, 0, 4'h0, 4'h0);

    foreach (vq[k]) begin
      @(negedge clk);
      rst_n          = !vq[k].rst;
      bus.press_in   = vq[k].press;
      bus.enable     = vq[k].en;
      bus.move_ready = vq[k].rdy;
      bus.frame_busy = vq[k].busy;
      bus.frame_done = vq[k].done;
      #1;
      chk("move_valid", k, 8'(bus.move_valid), 8'(vq[k].vld));
      if (vq[k].vld) chk("move_player", k, 8'(bus.move_player), 8'(vq[k].ply));
      chk("frame_start", k, 8'(bus.frame_start), 8'(vq[k].start));
      chk("pending", k, 8'(bus.pending), 8'(vq[k].pend));
      chk("dropped", k, 8'(bus.dropped), 8'(vq[k].drop));
      chk("timeout_flag", k, 8'(bus.timeout_flag), 8'h0);
    end

    // Press-to-grant latency, then frame_start gated by frame_busy
    do_reset();
    @(negedge clk);
    bus.press_in = 4'h8;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      bus.press_in = 4'h0;
      #1;
      if (bus.move_valid) begin
        lat = i;
        break;
      end
    end
    chk("press_latency", 0, 8'(lat), 8'd2);
    chk("latency_player", 0, 8'(bus.move_player), 8'(YELLOW));
    bus.move_ready = 1'b1;
    bus.frame_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.move_ready = 1'b0;
      #1;
      chk("start_while_busy", i, 8'(bus.frame_start), 8'h0);
    end
    @(negedge clk);
    bus.frame_busy = 1'b0;
    #1;
    chk("start_after_busy", 0, 8'(bus.frame_start), 8'h1);
    @(negedge clk);
    bus.frame_done = 1'b1;
    @(negedge clk);
    bus.frame_done = 1'b0;
    #1;
    chk("idle_after_done", 0, 8'({bus.move_valid, bus.frame_start}), 8'h0);

`ifdef ARB_TIMEOUT_EN
    // Frame never completes: watchdog returns to IDLE after 50 cycles
    do_reset();
    @(negedge clk);
    bus.press_in   = 4'h1;
    bus.move_ready = 1'b1;
    @(negedge clk);
    bus.press_in = 4'h0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("wd_frame_start", 0, 8'(bus.frame_start), 8'h1);
    @(negedge clk);
    repeat (49) @(negedge clk);
    #1;
    chk("wd_before_limit", 0, 8'(bus.timeout_flag), 8'h0);
    @(negedge clk);
    #1;
    chk("wd_flag", 0, 8'(bus.timeout_flag), 8'h1);
    bus.press_in = 4'h2;
    @(negedge clk);
    bus.press_in = 4'h0;
    @(negedge clk);
    #1;
    chk("wd_back_to_idle", 0, 8'({bus.move_valid, bus.move_player}), 8'({1'b1, RED}));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
